// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. Holds the MEM/WB pipeline register, chooses the value
// written back to the register file, keeps the architectural NZCV flags and a
// count of retired instructions. Every output comes straight from a register,
// so results appear one cycle after they are presented on the mem_* inputs.
//
// Ports
//   clk               in   1  clock, rising edge
//   reset             in   1  asynchronous reset, active low
//   stall             in   1  hold all state
//   flush             in   1  load a bubble (beats stall)
//   mem_mem_data      in  64  load data
//   mem_alu_result    in  64  ALU result
//   mem_bl_write_data in  64  link address for BL
//   mem_rd            in   5  destination register
//   mem_control_out   in   4  {RegWrite, MemToReg, SetFlags, BL}
//   mem_flags         in   4  {N,Z,C,V} from the instruction
//   wb_write_data     out 64  register file write data
//   wb_rd             out  5  register file write address
//   wb_reg_write      out  1  register file write enable
//   wb_valid          out  1  slot holds a real instruction
//   flags             out  4  architectural NZCV
//   retire_count      out 32  retired instruction count (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter logic [4:0] ZERO_REG   = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] mem_mem_data,
    input  logic [63:0] mem_alu_result,
    input  logic [63:0] mem_bl_write_data,
    input  logic [4:0]  mem_rd,
    input  logic [3:0]  mem_control_out,
    input  logic [3:0]  mem_flags,
    output logic [63:0] wb_write_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_valid,
    output logic [3:0]  flags,
    output logic [31:0] retire_count
);

    // Decoded incoming control bits.
    logic        w_ctl_reg_write;
    logic        w_ctl_mem_to_reg;
    logic        w_ctl_set_flags;
    logic        w_ctl_bl;
    logic [63:0] w_write_data;

    // MEM/WB register and architectural state.
    logic        r_valid;
    logic [63:0] r_write_data;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_set_flags;
    logic [3:0]  r_flags;
    logic [31:0] r_retire_count;

    assign w_ctl_reg_write  = mem_control_out[3];
    assign w_ctl_mem_to_reg = mem_control_out[2];
    assign w_ctl_set_flags  = mem_control_out[1];
    assign w_ctl_bl         = mem_control_out[0];

    // BL wins over MemToReg: the link address must not be replaced by load data.
    always_comb begin
        w_write_data = mem_alu_result;
        if (w_ctl_bl) begin
            w_write_data = mem_bl_write_data;
        end else if (w_ctl_mem_to_reg) begin
            w_write_data = mem_mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid        <= 1'b0;
            r_write_data   <= 64'd0;
            r_rd           <= 5'd0;
            r_reg_write    <= 1'b0;
            r_set_flags    <= 1'b0;
            r_flags        <= FLAG_RESET;
            r_retire_count <= 32'd0;
        end else if (flush) begin
            // Bubble: flags and retire count are left alone.
            r_valid      <= 1'b0;
            r_write_data <= 64'd0;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_set_flags  <= 1'b0;
        end else if (!stall) begin
            r_valid        <= 1'b1;
            r_write_data   <= w_write_data;
            r_rd           <= mem_rd;
            r_reg_write    <= w_ctl_reg_write;
            r_set_flags    <= w_ctl_set_flags;
            r_retire_count <= r_retire_count + 32'd1;
            if (w_ctl_set_flags) begin
                r_flags <= mem_flags;
            end
        end
    end

    assign wb_write_data = r_write_data;
    assign wb_rd         = r_rd;
    assign wb_valid      = r_valid;
    assign flags         = r_flags;
    assign retire_count  = r_retire_count;

    // Writes to the zero register are architecturally discarded.
    assign wb_reg_write = r_valid & r_reg_write & (r_rd != ZERO_REG);

    // r_set_flags is kept for visibility of the retired instruction's class.
    logic w_unused;
    assign w_unused = r_set_flags;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam logic [3:0] FlagRst = 4'b0101;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        valid;
        logic [3:0]  flg;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] mem_mem_data = '0;
    logic [63:0] mem_alu_result = '0;
    logic [63:0] mem_bl_write_data = '0;
    logic [4:0]  mem_rd = '0;
    logic [3:0]  mem_control_out = '0;
    logic [3:0]  mem_flags = '0;
    logic [63:0] wb_write_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_valid;
    logic [3:0]  flags;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    logic [3:0]  m_flags = FlagRst;
    logic [31:0] m_cnt = 32'd0;

    always #5 clk = ~clk;

    writeback_stage #(
        .FLAG_RESET(FlagRst),
        .ZERO_REG  (5'd31)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .mem_mem_data     (mem_mem_data),
        .mem_alu_result   (mem_alu_result),
        .mem_bl_write_data(mem_bl_write_data),
        .mem_rd           (mem_rd),
        .mem_control_out  (mem_control_out),
        .mem_flags        (mem_flags),
        .wb_write_data    (wb_write_data),
        .wb_rd            (wb_rd),
        .wb_reg_write     (wb_reg_write),
        .wb_valid         (wb_valid),
        .flags            (flags),
        .retire_count     (retire_count)
    );

    // Present one instruction, record what the WB stage must show afterwards,
    // then clock it in and settle just past the edge.
    task automatic drive(input logic [3:0] ctrl, input logic [63:0] md, input logic [63:0] alu,
                         input logic [63:0] bl, input logic [4:0] rd, input logic [3:0] fl);
        exp_t e;
        mem_control_out   = ctrl;
        mem_mem_data      = md;
        mem_alu_result    = alu;
        mem_bl_write_data = bl;
        mem_rd            = rd;
        mem_flags         = fl;
        stall             = 1'b0;
        flush             = 1'b0;
        e.data  = ctrl[0] ? bl : (ctrl[2] ? md : alu);
        e.rd    = rd;
        e.valid = 1'b1;
        e.we    = ctrl[3] && (rd != 5'd31);
        if (ctrl[1]) m_flags = fl;
        m_cnt   = m_cnt + 32'd1;
        e.flg   = m_flags;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_reg_write, wb_rd, wb_write_data} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b we=%b rd=%0d data=%h required all zero",
                     wb_valid, wb_reg_write, wb_rd, wb_write_data);
        end
        checks++;
        if (flags !== FlagRst || retire_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b cnt=%0d required flags=%b cnt=0",
                     flags, retire_count, FlagRst);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load();
        exp_t e;
        drive(4'b1100, 64'hDEAD_BEEF, 64'h1, 64'h2, 5'd5, 4'b0000);
        e = sb.pop_front();
        checks++;
        if (wb_write_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.we ||
            retire_count !== e.cnt) begin
            errors++;
            $display("FAIL load: got data=%h rd=%0d we=%b cnt=%0d required data=%h rd=%0d we=%b cnt=%0d",
                     wb_write_data, wb_rd, wb_reg_write, retire_count, e.data, e.rd, e.we, e.cnt);
        end
        checks++;
        if (wb_write_data !== 64'hDEAD_BEEF || retire_count !== 32'd1) begin
            errors++;
            $display("FAIL load_const: got data=%h cnt=%0d required deadbeef cnt=1",
                     wb_write_data, retire_count);
        end
    endtask

    task automatic test_bl_priority();
        exp_t e;
        drive(4'b1101, 64'h66, 64'h55, 64'h1004, 5'd30, 4'b0000);
        e = sb.pop_front();
        checks++;
        if (wb_write_data !== 64'h1004 || wb_rd !== 5'd30 || wb_reg_write !== 1'b1 ||
            retire_count !== e.cnt) begin
            errors++;
            $display("FAIL bl_priority: got data=%h rd=%0d we=%b cnt=%0d required data=1004 rd=30 we=1 cnt=%0d",
                     wb_write_data, wb_rd, wb_reg_write, retire_count, e.cnt);
        end
    endtask

    task automatic test_xzr();
        exp_t e;
        drive(4'b1000, 64'h0, 64'h7, 64'h0, 5'd31, 4'b0000);
        e = sb.pop_front();
        checks++;
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || retire_count !== e.cnt ||
            wb_write_data !== 64'h7) begin
            errors++;
            $display("FAIL xzr: got valid=%b we=%b data=%h cnt=%0d required valid=1 we=0 data=7 cnt=%0d",
                     wb_valid, wb_reg_write, wb_write_data, retire_count, e.cnt);
        end
    endtask

    task automatic test_flags();
        exp_t e;
        drive(4'b1010, 64'h0, 64'h10, 64'h0, 5'd1, 4'b0110);
        e = sb.pop_front();
        checks++;
        if (flags !== e.flg || flags !== 4'b0110) begin
            errors++;
            $display("FAIL flags_set: got %b required %b", flags, e.flg);
        end
        drive(4'b1000, 64'h0, 64'h20, 64'h0, 5'd2, 4'b1001);
        e = sb.pop_front();
        checks++;
        if (flags !== 4'b0110 || wb_write_data !== e.data || retire_count !== e.cnt) begin
            errors++;
            $display("FAIL flags_hold: got flags=%b data=%h cnt=%0d required flags=0110 data=%h cnt=%0d",
                     flags, wb_write_data, retire_count, e.data, e.cnt);
        end
    endtask

    task automatic test_no_regwrite();
        exp_t e;
        drive(4'b0000, 64'h0, 64'hABC, 64'h0, 5'd3, 4'b1111);
        e = sb.pop_front();
        checks++;
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || retire_count !== e.cnt ||
            flags !== e.flg) begin
            errors++;
            $display("FAIL no_regwrite: got valid=%b we=%b cnt=%0d flags=%b required valid=1 we=0 cnt=%0d flags=%b",
                     wb_valid, wb_reg_write, retire_count, flags, e.cnt, e.flg);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 4'($urandom));
            e = sb.pop_front();
            checks++;
            if (wb_write_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.we ||
                wb_valid !== e.valid || flags !== e.flg || retire_count !== e.cnt) begin
                errors++;
                $display("FAIL b2b[%0d]: got data=%h rd=%0d we=%b v=%b f=%b c=%0d required data=%h rd=%0d we=%b v=%b f=%b c=%0d",
                         i, wb_write_data, wb_rd, wb_reg_write, wb_valid, flags, retire_count,
                         e.data, e.rd, e.we, e.valid, e.flg, e.cnt);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        drive(4'b1110, 64'h1234, 64'h9, 64'h0, 5'd8, 4'b0011);
        e = sb.pop_front();
        // Different instruction waiting while stalled; must not enter.
        stall           = 1'b1;
        mem_control_out = 4'b1011;
        mem_alu_result  = 64'hFFFF;
        mem_rd          = 5'd9;
        mem_flags       = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wb_write_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.we ||
                wb_valid !== 1'b1 || flags !== e.flg || retire_count !== e.cnt) begin
                errors++;
                $display("FAIL stall[%0d]: got data=%h rd=%0d we=%b f=%b c=%0d required data=%h rd=%0d we=%b f=%b c=%0d",
                         i, wb_write_data, wb_rd, wb_reg_write, flags, retire_count,
                         e.data, e.rd, e.we, e.flg, e.cnt);
            end
        end
    endtask

    task automatic test_flush();
        // stall still 1; flush must win and must not touch flags.
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_rd !== 5'd0 ||
            wb_write_data !== 64'd0) begin
            errors++;
            $display("FAIL flush_bubble: got valid=%b we=%b rd=%0d data=%h required zeros",
                     wb_valid, wb_reg_write, wb_rd, wb_write_data);
        end
        checks++;
        if (flags !== m_flags || retire_count !== m_cnt) begin
            errors++;
            $display("FAIL flush_state: got flags=%b cnt=%0d required flags=%b cnt=%0d",
                     flags, retire_count, m_flags, m_cnt);
        end
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(4'b1100, 64'h77, 64'h0, 64'h0, 5'd4, 4'b0000);
        e = sb.pop_front();
        checks++;
        if (wb_reg_write !== 1'b1 || retire_count !== e.cnt) begin
            errors++;
            $display("FAIL pre_reset: got we=%b cnt=%0d required we=1 cnt=%0d",
                     wb_reg_write, retire_count, e.cnt);
        end
        stall = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_reg_write, wb_rd, wb_write_data} !== 71'd0 || flags !== FlagRst ||
            retire_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b we=%b rd=%0d data=%h f=%b c=%0d required zeros f=%b",
                     wb_valid, wb_reg_write, wb_rd, wb_write_data, flags, retire_count, FlagRst);
        end
        m_flags = FlagRst;
        m_cnt   = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1000, 64'h0, 64'hBEEF, 64'h0, 5'd6, 4'b0000);
        e = sb.pop_front();
        checks++;
        if (retire_count !== 32'd1 || wb_write_data !== e.data || wb_rd !== e.rd ||
            flags !== FlagRst) begin
            errors++;
            $display("FAIL post_reset: got cnt=%0d data=%h rd=%0d f=%b required cnt=1 data=%h rd=%0d f=%b",
                     retire_count, wb_write_data, wb_rd, flags, e.data, e.rd, FlagRst);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bl_priority();
        test_xzr();
        test_flags();
        test_no_regwrite();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish within 100000 time units");
        $fatal(1);
    end

endmodule
